clos_cfg_alloc: RTL and testbench

- Synchronous path allocator for the parametrised data Clos switch (IMs → MN CMs → output ports).
- Accepts circuit set-up and release requests, one at a time.
- Finds a middle module whose IM-side and output-side links are both free, and keeps the IM and CM configuration vectors in registers.
- Generalises the fixed 5-port, hand-wired Clos configuration to PN ports, adds dynamic allocation and release, and reports allocation failures.

---
 rtl/clos_cfg_alloc_if.sv | 42 ++++
 rtl/clos_cfg_alloc.sv | 196 +++++++++++++++++++
 tb/tb_clos_cfg_alloc.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clos_cfg_alloc_if.sv
// Request/release/response bundle and configuration outputs for clos_cfg_alloc.
// master drives requests; slave is the allocator.
interface clos_cfg_alloc_if #(
    parameter int PN = 5,
    parameter int NN = 2,
    parameter int MN = 2,
    parameter int PW = (PN > 1) ? $clog2(PN) : 1,
    parameter int VW = (NN > 1) ? $clog2(NN) : 1,
    parameter int MW = (MN > 1) ? $clog2(MN) : 1
);
    logic                   req_valid;
    logic                   req_ready;
    logic [PW-1:0]          req_src;
    logic [VW-1:0]          req_vc;
    logic [PW-1:0]          req_dst;
    logic                   rel_valid;
    logic                   rel_ready;
    logic [PW-1:0]          rel_src;
    logic [VW-1:0]          rel_vc;
    logic                   rsp_valid;
    logic                   rsp_ok;
    logic [1:0]             rsp_err;
    logic [MW-1:0]          rsp_cm;
    logic [PN*MN*NN-1:0]    imcfg;
    logic [MN*PN*PN-1:0]    cmcfg;

    modport master (
        output req_valid, req_src, req_vc, req_dst,
        output rel_valid, rel_src, rel_vc,
        input  req_ready, rel_ready,
        input  rsp_valid, rsp_ok, rsp_err, rsp_cm,
        input  imcfg, cmcfg
    );

    modport slave (
        input  req_valid, req_src, req_vc, req_dst,
        input  rel_valid, rel_src, rel_vc,
        output req_ready, rel_ready,
        output rsp_valid, rsp_ok, rsp_err, rsp_cm,
        output imcfg, cmcfg
    );
endinterface

// File: rtl/clos_cfg_alloc.sv
// Path allocator for a PN-port Clos switch: scans MN middle modules for a
// CM with free IM-side and output-side links, keeps IM/CM config registers.
module clos_cfg_alloc #(
    parameter int PN = 5,
    parameter int NN = 2,
    parameter int MN = 2,
    parameter int PW = (PN > 1) ? $clog2(PN) : 1,
    parameter int VW = (NN > 1) ? $clog2(NN) : 1,
    parameter int MW = (MN > 1) ? $clog2(MN) : 1
) (
    input  logic            clk,
    input  logic            rst,
    clos_cfg_alloc_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] REL   = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_BUSY = 2'd1;
    localparam logic [1:0] ERR_FULL = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [MW-1:0] m_q, m_d;
    logic [PW-1:0] src_q, src_d;
    logic [VW-1:0] vc_q, vc_d;
    logic [PW-1:0] dst_q, dst_d;

    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_ok_q, rsp_ok_d;
    logic [1:0]    rsp_err_q, rsp_err_d;
    logic [MW-1:0] rsp_cm_q, rsp_cm_d;

    logic [MN-1:0] im_busy_q [PN];
    logic [MN-1:0] om_busy_q [PN];
    logic          conn_v_q   [PN][NN];
    logic [MW-1:0] conn_cm_q  [PN][NN];
    logic [PW-1:0] conn_dst_q [PN][NN];
    logic [NN-1:0] imcfg_q [PN][MN];
    logic [PN-1:0] cmcfg_q [MN][PN];

    logic          commit;
    logic          clear;
    logic          cm_free;
    logic          conn_hit;
    logic [MW-1:0] rel_cm;
    logic [PW-1:0] rel_dst;

    assign conn_hit = conn_v_q[src_q][vc_q];
    assign rel_cm   = conn_cm_q[src_q][vc_q];
    assign rel_dst  = conn_dst_q[src_q][vc_q];
    assign cm_free  = !im_busy_q[src_q][m_q] && !om_busy_q[dst_q][m_q];

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        src_d     = src_q;
        vc_d      = vc_q;
        dst_d     = dst_q;
        rsp_ok_d  = rsp_ok_q;
        rsp_err_d = rsp_err_q;
        rsp_cm_d  = rsp_cm_q;
        commit    = 1'b0;
        clear     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Release wins when both are offered in the same cycle.
                if (bus.rel_valid) begin
                    src_d   = bus.rel_src;
                    vc_d    = bus.rel_vc;
                    state_d = REL;
                end else if (bus.req_valid) begin
                    src_d   = bus.req_src;
                    vc_d    = bus.req_vc;
                    dst_d   = bus.req_dst;
                    m_d     = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (m_q == '0 && conn_hit) begin
                    rsp_ok_d  = 1'b0;
                    rsp_err_d = ERR_BUSY;
                    state_d   = RESP;
                end else if (cm_free) begin
                    commit    = 1'b1;
                    rsp_ok_d  = 1'b1;
                    rsp_err_d = ERR_NONE;
                    rsp_cm_d  = m_q;
                    state_d   = RESP;
                end else if (m_q == MW'(MN - 1)) begin
                    rsp_ok_d  = 1'b0;
                    rsp_err_d = ERR_FULL;
                    state_d   = RESP;
                end else begin
                    m_d = m_q + MW'(1);
                end
            end
            REL: begin
                if (!conn_hit) begin
                    rsp_ok_d  = 1'b0;
                    rsp_err_d = ERR_BUSY;
                end else begin
                    clear     = 1'b1;
                    rsp_ok_d  = 1'b1;
                    rsp_err_d = ERR_NONE;
                    rsp_cm_d  = rel_cm;
                end
                state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid_d = (state_d == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            m_q         <= '0;
            src_q       <= '0;
            vc_q        <= '0;
            dst_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            rsp_err_q   <= '0;
            rsp_cm_q    <= '0;
            for (int p = 0; p < PN; p++) begin
                im_busy_q[p] <= '0;
                om_busy_q[p] <= '0;
                for (int v = 0; v < NN; v++) begin
                    conn_v_q[p][v]   <= 1'b0;
                    conn_cm_q[p][v]  <= '0;
                    conn_dst_q[p][v] <= '0;
                end
                for (int m = 0; m < MN; m++) begin
                    imcfg_q[p][m] <= '0;
                end
            end
            for (int m = 0; m < MN; m++) begin
                for (int o = 0; o < PN; o++) begin
                    cmcfg_q[m][o] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            src_q       <= src_d;
            vc_q        <= vc_d;
            dst_q       <= dst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ok_q    <= rsp_ok_d;
            rsp_err_q   <= rsp_err_d;
            rsp_cm_q    <= rsp_cm_d;
            if (commit) begin
                im_busy_q[src_q][m_q]         <= 1'b1;
                om_busy_q[dst_q][m_q]         <= 1'b1;
                conn_v_q[src_q][vc_q]         <= 1'b1;
                conn_cm_q[src_q][vc_q]        <= m_q;
                conn_dst_q[src_q][vc_q]       <= dst_q;
                imcfg_q[src_q][m_q][vc_q]     <= 1'b1;
                cmcfg_q[m_q][dst_q][src_q]    <= 1'b1;
            end
            if (clear) begin
                im_busy_q[src_q][rel_cm]      <= 1'b0;
                om_busy_q[rel_dst][rel_cm]    <= 1'b0;
                conn_v_q[src_q][vc_q]         <= 1'b0;
                imcfg_q[src_q][rel_cm][vc_q]  <= 1'b0;
                cmcfg_q[rel_cm][rel_dst][src_q] <= 1'b0;
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE) && !bus.rel_valid;
    assign bus.rel_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_ok    = rsp_ok_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_cm    = rsp_cm_q;

    for (genvar p = 0; p < PN; p++) begin : g_im
        for (genvar m = 0; m < MN; m++) begin : g_m
            assign bus.imcfg[(p*MN+m)*NN +: NN] = imcfg_q[p][m];
        end
    end

    for (genvar m = 0; m < MN; m++) begin : g_cm
        for (genvar o = 0; o < PN; o++) begin : g_o
            assign bus.cmcfg[(m*PN+o)*PN +: PN] = cmcfg_q[m][o];
        end
    end

endmodule

// File: tb/tb_clos_cfg_alloc.sv
// Directed bench for clos_cfg_alloc: expected responses are queued when a
// request is driven and checked, with latency and config vectors, on rsp_valid.
module tb_clos_cfg_alloc;

    localparam int PN = 5;
    localparam int NN = 2;
    localparam int MN = 2;
    localparam int PW = 3;
    localparam int VW = 1;
    localparam int MW = 1;

    typedef struct {
        string      tag;
        bit         ok;
        logic [1:0] err;
        int         cm;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];

    logic [PN*MN*NN-1:0] exp_im = '0;
    logic [MN*PN*PN-1:0] exp_cm = '0;

    clos_cfg_alloc_if #(.PN(PN), .NN(NN), .MN(MN)) bus ();

    clos_cfg_alloc #(.PN(PN), .NN(NN), .MN(MN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void mset(int p, int m, int v, int o, bit val);
        exp_im[(p*MN+m)*NN+v] = val;
        exp_cm[(m*PN+o)*PN+p] = val;
    endfunction

    task automatic expect_rsp(string tag, bit ok, logic [1:0] err,
                              int cm, int lat);
        exp_t e;
        e.tag = tag; e.ok = ok; e.err = err; e.cm = cm; e.lat = lat;
        sbq.push_back(e);
    endtask

    task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic chk_cfg(string tag);
        total++;
        assert (bus.imcfg === exp_im) else begin
            bad++;
            $error("FAIL %s imcfg: got %0h want %0h", tag, bus.imcfg, exp_im);
        end
        total++;
        assert (bus.cmcfg === exp_cm) else begin
            bad++;
            $error("FAIL %s cmcfg: got %0h want %0h", tag, bus.cmcfg, exp_cm);
        end
    endtask

    task automatic wait_accept(bit is_rel);
        bit acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            acc = is_rel ? bus.rel_ready : bus.req_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        #1;
        chk(is_rel ? "rel_accept" : "req_accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_rsp();
        exp_t e;
        int lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        assert (sbq.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard: got empty queue want entry");
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({e.tag, "_lat"}, 64'(lat), 64'(e.lat));
            chk({e.tag, "_ok"}, 64'(bus.rsp_ok), 64'(e.ok));
            chk({e.tag, "_err"}, 64'(bus.rsp_err), 64'(e.err));
            if (e.ok) chk({e.tag, "_cm"}, 64'(bus.rsp_cm), 64'(e.cm));
            chk_cfg(e.tag);
        end
        @(posedge clk);
        #1;
        chk("rsp_pulse", 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic do_req(int s, int v, int d);
        @(negedge clk);
        bus.req_src   = PW'(s);
        bus.req_vc    = VW'(v);
        bus.req_dst   = PW'(d);
        bus.req_valid = 1'b1;
        wait_accept(1'b0);
        bus.req_valid = 1'b0;
        wait_rsp();
    endtask

    task automatic do_rel(int s, int v);
        @(negedge clk);
        bus.rel_src   = PW'(s);
        bus.rel_vc    = VW'(v);
        bus.rel_valid = 1'b1;
        wait_accept(1'b1);
        bus.rel_valid = 1'b0;
        wait_rsp();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_src   = '0;
        bus.req_vc    = '0;
        bus.req_dst   = '0;
        bus.rel_valid = 1'b0;
        bus.rel_src   = '0;
        bus.rel_vc    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rel_ready", 64'(bus.rel_ready), 64'd1);
        chk_cfg("rst");

        mset(0, 0, 0, 2, 1'b1);
        expect_rsp("s00_d2", 1'b1, 2'd0, 0, 1);
        do_req(0, 0, 2);

        mset(0, 1, 1, 3, 1'b1);
        expect_rsp("s01_d3", 1'b1, 2'd0, 1, 2);
        do_req(0, 1, 3);

        mset(2, 0, 0, 4, 1'b1);
        expect_rsp("s20_d4", 1'b1, 2'd0, 0, 1);
        do_req(2, 0, 4);

        mset(1, 1, 1, 4, 1'b1);
        expect_rsp("s11_d4", 1'b1, 2'd0, 1, 2);
        do_req(1, 1, 4);

        expect_rsp("s10_full", 1'b0, 2'd2, 0, 2);
        do_req(1, 0, 2);

        expect_rsp("s00_dup", 1'b0, 2'd1, 0, 1);
        do_req(0, 0, 2);

        expect_rsp("rel31_nc", 1'b0, 2'd1, 0, 1);
        do_rel(3, 1);

        mset(0, 0, 0, 2, 1'b0);
        expect_rsp("rel00", 1'b1, 2'd0, 0, 1);
        do_rel(0, 0);

        mset(1, 0, 0, 2, 1'b1);
        expect_rsp("s10_d2", 1'b1, 2'd0, 0, 1);
        do_req(1, 0, 2);

        // Release and request offered together.
        @(negedge clk);
        bus.rel_src   = 3'd1;
        bus.rel_vc    = 1'b0;
        bus.rel_valid = 1'b1;
        bus.req_src   = 3'd3;
        bus.req_vc    = 1'b0;
        bus.req_dst   = 3'd0;
        bus.req_valid = 1'b1;
        #1;
        chk("both_req_ready", 64'(bus.req_ready), 64'd0);
        chk("both_rel_ready", 64'(bus.rel_ready), 64'd1);
        mset(1, 0, 0, 2, 1'b0);
        expect_rsp("both_rel10", 1'b1, 2'd0, 0, 1);
        @(posedge clk);
        #1;
        bus.rel_valid = 1'b0;
        wait_rsp();
        mset(3, 0, 0, 0, 1'b1);
        expect_rsp("both_s30", 1'b1, 2'd0, 0, 1);
        wait_accept(1'b0);
        bus.req_valid = 1'b0;
        wait_rsp();

        mset(2, 1, 1, 2, 1'b1);
        expect_rsp("s21_d2", 1'b1, 2'd0, 1, 2);
        do_req(2, 1, 2);

        // Reset while the allocator is in CHECK.
        @(negedge clk);
        bus.req_src   = 3'd4;
        bus.req_vc    = 1'b0;
        bus.req_dst   = 3'd1;
        bus.req_valid = 1'b1;
        wait_accept(1'b0);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        exp_im = '0;
        exp_cm = '0;
        @(posedge clk);
        #1;
        chk("rstchk_rsp0", 64'(bus.rsp_valid), 64'd0);
        chk_cfg("rstchk");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rstchk_rsp1", 64'(bus.rsp_valid), 64'd0);
        end
        chk("rstchk_ready", 64'(bus.req_ready), 64'd1);

        mset(0, 0, 1, 3, 1'b1);
        expect_rsp("post_rst_s01", 1'b1, 2'd0, 0, 1);
        do_req(0, 1, 3);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
